// File: rtl/spi_sched.sv
// Round-robin scheduler for two requesters sharing the 24-bit SPI word driver.
// Frames every word with CSn setup/hold/gap timing and a BUSY watchdog.
module spi_sched #(
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned CS_HOLD  = 4,
  parameter int unsigned CS_GAP   = 8,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [23:0] data0,
  input  logic [23:0] data1,
  input  logic        sel0,
  input  logic        sel1,
  output logic        ack0,
  output logic        ack1,
  output logic        done0,
  output logic        done1,
  output logic        spi_we,
  output logic [23:0] spi_tx,
  input  logic        spi_running,
  output logic [1:0]  csn,
  output logic        busy,
  output logic        owner,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_START = 3'd2,
    S_BUSY  = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  localparam logic [7:0]  SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0]  HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0]  GAP_LAST   = 8'(CS_GAP - 1);
  localparam logic [15:0] WD_LAST    = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] wd_q, wd_d;
  logic        cs_idx_q, cs_idx_d;
  logic        owner_q, owner_d;
  logic [23:0] spi_tx_q, spi_tx_d;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  done_q, done_d;
  logic        spi_we_q, spi_we_d;
  logic [1:0]  csn_q, csn_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        grant_one_s;

  // On a tie the requester that is not the current owner wins.
  assign grant_one_s = req1 & (~req0 | ~owner_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wd_d     = wd_q;
    cs_idx_d = cs_idx_q;
    owner_d  = owner_q;
    spi_tx_d = spi_tx_q;
    ack_d    = 2'b00;
    done_d   = 2'b00;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (!spi_running && (req0 || req1)) begin
          state_d  = S_SETUP;
          cnt_d    = 8'd0;
          owner_d  = grant_one_s;
          cs_idx_d = grant_one_s ? sel1 : sel0;
          spi_tx_d = grant_one_s ? data1 : data0;
          ack_d    = grant_one_s ? 2'b10 : 2'b01;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_START;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_START: begin
        state_d = S_BUSY;
        wd_d    = 16'd0;
      end
      S_BUSY: begin
        // wd_q == 0 marks the first BUSY cycle, where spi_running still lags spi_we.
        if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_HOLD;
          cnt_d   = 8'd0;
        end else if ((wd_q != 16'd0) && !spi_running) begin
          state_d = S_HOLD;
          cnt_d   = 8'd0;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_GAP;
          cnt_d   = 8'd0;
          done_d  = owner_q ? 2'b10 : 2'b01;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    spi_we_d = (state_d == S_START);
    busy_d   = (state_d != S_IDLE);
    if (state_d inside {S_SETUP, S_START, S_BUSY, S_HOLD}) begin
      csn_d = cs_idx_d ? 2'b01 : 2'b10;
    end else begin
      csn_d = 2'b11;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      wd_q     <= 16'd0;
      cs_idx_q <= 1'b0;
      owner_q  <= 1'b1;
      spi_tx_q <= 24'd0;
      ack_q    <= 2'b00;
      done_q   <= 2'b00;
      spi_we_q <= 1'b0;
      csn_q    <= 2'b11;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wd_q     <= wd_d;
      cs_idx_q <= cs_idx_d;
      owner_q  <= owner_d;
      spi_tx_q <= spi_tx_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      spi_we_q <= spi_we_d;
      csn_q    <= csn_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign ack0   = ack_q[0];
  assign ack1   = ack_q[1];
  assign done0  = done_q[0];
  assign done1  = done_q[1];
  assign spi_we = spi_we_q;
  assign spi_tx = spi_tx_q;
  assign csn    = csn_q;
  assign busy   = busy_q;
  assign owner  = owner_q;
  assign err    = err_q;

endmodule
